// File: rtl/burst_main_decoder.sv
// burst_main_decoder
//   Registered main decoder with a multi-channel colour burst sequencer.
//   An accepted instruction is decoded into datapath controls that appear
//   one cycle later. A colour LD/ST with multi=1 walks channels
//   1..NUM_CHANNELS against the pixel memory and holds fetch until the
//   burst completes.
//
//   Optional feature macro: MAIN_DECODER_BURST_TIMEOUT_EN
//     defined   : per-beat watchdog aborts a stuck burst and pulses err
//     undefined : no watchdog, err tied low, a burst waits indefinitely
//
//   Ports
//     clk, rst         clock, asynchronous active-high reset
//     valid            instruction present on tipo/op/Inm/multi
//     tipo, op, Inm    instruction type, operation, immediate bit
//     multi            burst request (colour LD/ST only)
//     mem_ready        pixel memory completed the current beat
//     RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp
//                      datapath controls
//     chan             colour channel accessed (0 = none)
//     stall            hold fetch while not idle
//     done             one-cycle pulse at burst completion
//     err              one-cycle pulse at burst timeout
module burst_main_decoder #(
    parameter  int unsigned NUM_CHANNELS   = 3,
    parameter  int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned CH_W           = $clog2(NUM_CHANNELS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic [1:0]      tipo,
    input  logic [1:0]      op,
    input  logic            Inm,
    input  logic            multi,
    input  logic            mem_ready,
    output logic            RegWrite,
    output logic [1:0]      ImmSrc,
    output logic            ALUSrc,
    output logic            MemWrite,
    output logic            ResultSrc,
    output logic            Branch,
    output logic [1:0]      ALUOp,
    output logic [CH_W-1:0] chan,
    output logic            stall,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ISSUE = 2'b01;
    localparam logic [1:0] S_BURST = 2'b10;

    // Elaboration-time parameter sanity checks
    if (NUM_CHANNELS < 3) begin : g_bad_channels
        $error("burst_main_decoder: NUM_CHANNELS must be at least 3");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("burst_main_decoder: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_regwrite_nxt;
    logic            w_alusrc_nxt;
    logic            w_memwrite_nxt;
    logic            w_resultsrc_nxt;
    logic            w_branch_nxt;
    logic [1:0]      w_aluop_nxt;
    logic [CH_W-1:0] w_chan_nxt;
    logic            w_done_nxt;
    logic            w_colour;
    logic            w_start_burst;
    logic            w_last_beat;

`ifdef MAIN_DECODER_BURST_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_err_nxt;
    logic             w_timeout;
`endif

    // Colour LD (tipo 01) and colour ST (tipo 11) share tipo[0]=1 with op!=0
    assign w_colour      = tipo[0] && (op != 2'b00);
    assign w_start_burst = multi && w_colour;
    assign w_last_beat   = (chan == CH_W'(NUM_CHANNELS));

    // No immediate extension modes exist in this generation
    assign ImmSrc = 2'b00;

`ifdef MAIN_DECODER_BURST_TIMEOUT_EN
    assign w_timeout = !mem_ready && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = S_IDLE;
        w_regwrite_nxt  = 1'b0;
        w_alusrc_nxt    = 1'b0;
        w_memwrite_nxt  = 1'b0;
        w_resultsrc_nxt = 1'b0;
        w_branch_nxt    = 1'b0;
        w_aluop_nxt     = 2'b00;
        w_chan_nxt      = '0;
        w_done_nxt      = 1'b0;
`ifdef MAIN_DECODER_BURST_TIMEOUT_EN
        w_cnt_nxt       = '0;
        w_err_nxt       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (valid) begin
                    w_state_nxt = w_start_burst ? S_BURST : S_ISSUE;
                    case (tipo)
                        2'b00: begin
                            w_regwrite_nxt = 1'b1;
                            w_alusrc_nxt   = Inm;
                            w_aluop_nxt    = 2'b10;
                        end
                        2'b01: begin
                            w_regwrite_nxt = 1'b1;
                            w_alusrc_nxt   = Inm;
                            if (op != 2'b00) begin
                                w_resultsrc_nxt = 1'b1;
                                // A burst always starts at channel 1 regardless of op
                                w_chan_nxt = w_start_burst ? CH_W'(1) : CH_W'(op);
                            end
                        end
                        2'b10: begin
                            if (op == 2'b10) begin
                                w_aluop_nxt = 2'b01;
                            end else begin
                                w_branch_nxt = 1'b1;
                            end
                        end
                        default: begin
                            w_alusrc_nxt = Inm;
                            if (op == 2'b00) begin
                                w_branch_nxt   = 1'b1;
                                w_regwrite_nxt = 1'b1;
                                w_aluop_nxt    = 2'b01;
                            end else begin
                                w_memwrite_nxt = 1'b1;
                                w_chan_nxt     = w_start_burst ? CH_W'(1) : CH_W'(op);
                            end
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_IDLE;
            end
            S_BURST: begin
                if (mem_ready && w_last_beat) begin
                    w_done_nxt = 1'b1;
`ifdef MAIN_DECODER_BURST_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_err_nxt = 1'b1;
`endif
                end else begin
                    // Hold beat controls; only the channel advances on a handshake
                    w_state_nxt     = S_BURST;
                    w_regwrite_nxt  = RegWrite;
                    w_alusrc_nxt    = ALUSrc;
                    w_memwrite_nxt  = MemWrite;
                    w_resultsrc_nxt = ResultSrc;
                    w_branch_nxt    = Branch;
                    w_aluop_nxt     = ALUOp;
                    w_chan_nxt      = mem_ready ? (chan + CH_W'(1)) : chan;
`ifdef MAIN_DECODER_BURST_TIMEOUT_EN
                    w_cnt_nxt       = mem_ready ? '0 : (r_cnt + CNT_W'(1));
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            RegWrite  <= 1'b0;
            ALUSrc    <= 1'b0;
            MemWrite  <= 1'b0;
            ResultSrc <= 1'b0;
            Branch    <= 1'b0;
            ALUOp     <= 2'b00;
            chan      <= '0;
            stall     <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            RegWrite  <= w_regwrite_nxt;
            ALUSrc    <= w_alusrc_nxt;
            MemWrite  <= w_memwrite_nxt;
            ResultSrc <= w_resultsrc_nxt;
            Branch    <= w_branch_nxt;
            ALUOp     <= w_aluop_nxt;
            chan      <= w_chan_nxt;
            stall     <= (w_state_nxt != S_IDLE);
            done      <= w_done_nxt;
        end
    end

`ifdef MAIN_DECODER_BURST_TIMEOUT_EN
    // Per-beat watchdog counter and timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            err   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            err   <= w_err_nxt;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_main_decoder.sv
// tb_burst_main_decoder
//   Directed bench for burst_main_decoder with NUM_CHANNELS=4 and
//   TIMEOUT_CYCLES=4. A vector table covers every single-cycle decode;
//   hand-written sequences cover bursts, stalls, reset and timeout.
module tb_burst_main_decoder;

    localparam int unsigned NCH = 4;
    localparam int unsigned CHW = 3;
    localparam int unsigned TO  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid;
    logic [1:0]     tipo;
    logic [1:0]     op;
    logic           Inm;
    logic           multi;
    logic           mem_ready;
    logic           RegWrite;
    logic [1:0]     ImmSrc;
    logic           ALUSrc;
    logic           MemWrite;
    logic           ResultSrc;
    logic           Branch;
    logic [1:0]     ALUOp;
    logic [CHW-1:0] chan;
    logic           stall;
    logic           done;
    logic           err;

    int n_chk  = 0;
    int n_fail = 0;

    burst_main_decoder #(
        .NUM_CHANNELS  (NCH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .tipo     (tipo),
        .op       (op),
        .Inm      (Inm),
        .multi    (multi),
        .mem_ready(mem_ready),
        .RegWrite (RegWrite),
        .ImmSrc   (ImmSrc),
        .ALUSrc   (ALUSrc),
        .MemWrite (MemWrite),
        .ResultSrc(ResultSrc),
        .Branch   (Branch),
        .ALUOp    (ALUOp),
        .chan     (chan),
        .stall    (stall),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  tipo;
        logic [1:0]  op;
        logic        inm;
        logic        multi;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[13];

    // Expected control word {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, chan}
    function automatic logic [11:0] mk(input logic rw, input logic alusrc, input logic mw,
                                       input logic rs, input logic br,
                                       input logic [1:0] aluop, input logic [2:0] ch);
        return {rw, 2'b00, alusrc, mw, rs, br, aluop, ch};
    endfunction

    function automatic logic [11:0] outs();
        return {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, chan};
    endfunction

    // {stall, done, err}
    function automatic logic [2:0] sde();
        return {stall, done, err};
    endfunction

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] t, input logic [1:0] o, input logic i, input logic m);
        valid = 1'b1;
        tipo  = t;
        op    = o;
        Inm   = i;
        multi = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b00, 2'b00, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 2'b10, 3'd0)};
        vecs[1]  = '{2'b00, 2'b11, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 2'b10, 3'd0)};
        vecs[2]  = '{2'b01, 2'b00, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 2'b00, 3'd0)};
        vecs[3]  = '{2'b01, 2'b10, 1'b0, 1'b0, mk(1, 0, 0, 1, 0, 2'b00, 3'd2)};
        vecs[4]  = '{2'b01, 2'b11, 1'b1, 1'b0, mk(1, 1, 0, 1, 0, 2'b00, 3'd3)};
        vecs[5]  = '{2'b10, 2'b00, 1'b1, 1'b0, mk(0, 0, 0, 0, 1, 2'b00, 3'd0)};
        vecs[6]  = '{2'b10, 2'b01, 1'b0, 1'b1, mk(0, 0, 0, 0, 1, 2'b00, 3'd0)};
        vecs[7]  = '{2'b10, 2'b10, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 2'b01, 3'd0)};
        vecs[8]  = '{2'b10, 2'b11, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 2'b00, 3'd0)};
        vecs[9]  = '{2'b11, 2'b00, 1'b1, 1'b1, mk(1, 1, 0, 0, 1, 2'b01, 3'd0)};
        vecs[10] = '{2'b11, 2'b01, 1'b1, 1'b0, mk(0, 1, 1, 0, 0, 2'b00, 3'd1)};
        vecs[11] = '{2'b11, 2'b11, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 2'b00, 3'd3)};
        vecs[12] = '{2'b01, 2'b01, 1'b1, 1'b0, mk(1, 1, 0, 1, 0, 2'b00, 3'd1)};

        rst       = 1'b1;
        valid     = 1'b0;
        tipo      = 2'b00;
        op        = 2'b00;
        Inm       = 1'b0;
        multi     = 1'b0;
        mem_ready = 1'b0;
        #3;
        chk("reset_outs", outs(), 12'h000);
        chk("reset_sde", 12'(sde()), 12'h000);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single-cycle decodes, presented back to back
        for (int i = 0; i < 13; i++) begin
            present(vecs[i].tipo, vecs[i].op, vecs[i].inm, vecs[i].multi);
            mem_ready = 1'b0;
            tick();
            chk($sformatf("vec%0d_outs", i), outs(), vecs[i].exp);
            chk($sformatf("vec%0d_sde", i), 12'(sde()), 12'h004);
            valid     = 1'b0;
            mem_ready = 1'b1;
            tick();
            chk($sformatf("vec%0d_clear", i), outs(), 12'h000);
            chk($sformatf("vec%0d_sde_clear", i), 12'(sde()), 12'h000);
        end

        // ST burst with mem_ready on alternate cycles; junk valid held during burst
        present(2'b11, 2'b01, 1'b1, 1'b1);
        mem_ready = 1'b0;
        tick();
        chk("stb_entry", outs(), mk(0, 1, 1, 0, 0, 2'b00, 3'd1));
        chk("stb_entry_sde", 12'(sde()), 12'h004);
        present(2'b00, 2'b00, 1'b0, 1'b0);
        for (int ch = 1; ch <= 4; ch++) begin
            mem_ready = 1'b0;
            tick();
            chk($sformatf("stb_hold%0d", ch), outs(), mk(0, 1, 1, 0, 0, 2'b00, 3'(ch)));
            chk($sformatf("stb_hold%0d_sde", ch), 12'(sde()), 12'h004);
            mem_ready = 1'b1;
            tick();
            if (ch < 4) begin
                chk($sformatf("stb_adv%0d", ch), outs(), mk(0, 1, 1, 0, 0, 2'b00, 3'(ch + 1)));
                chk($sformatf("stb_adv%0d_sde", ch), 12'(sde()), 12'h004);
            end else begin
                chk("stb_exit", outs(), 12'h000);
                chk("stb_exit_sde", 12'(sde()), 12'h002);
            end
        end
        valid     = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk("stb_after", outs(), 12'h000);
        chk("stb_after_sde", 12'(sde()), 12'h000);

        // LD burst, op ignored for channel selection, mem_ready always high
        present(2'b01, 2'b11, 1'b0, 1'b1);
        mem_ready = 1'b1;
        tick();
        valid = 1'b0;
        chk("ldb_ch1", outs(), mk(1, 0, 0, 1, 0, 2'b00, 3'd1));
        for (int ch = 2; ch <= 4; ch++) begin
            tick();
            chk($sformatf("ldb_ch%0d", ch), outs(), mk(1, 0, 0, 1, 0, 2'b00, 3'(ch)));
            chk($sformatf("ldb_ch%0d_sde", ch), 12'(sde()), 12'h004);
        end
        tick();
        chk("ldb_exit", outs(), 12'h000);
        chk("ldb_exit_sde", 12'(sde()), 12'h002);
        // Accepted with no bubble right after burst exit
        present(2'b10, 2'b10, 1'b0, 1'b0);
        tick();
        chk("b2b_cmp", outs(), mk(0, 0, 0, 0, 0, 2'b01, 3'd0));
        chk("b2b_cmp_sde", 12'(sde()), 12'h004);
        valid = 1'b0;
        tick();

        // mem_ready held low: waits (default) or times out (watchdog enabled)
        present(2'b11, 2'b10, 1'b0, 1'b1);
        mem_ready = 1'b0;
        tick();
        valid = 1'b0;
        chk("wait_entry", outs(), mk(0, 0, 1, 0, 0, 2'b00, 3'd1));
        for (int k = 1; k <= 6; k++) begin
            tick();
`ifdef MAIN_DECODER_BURST_TIMEOUT_EN
            if (k < 4) begin
                chk($sformatf("to_hold%0d", k), outs(), mk(0, 0, 1, 0, 0, 2'b00, 3'd1));
                chk($sformatf("to_hold%0d_sde", k), 12'(sde()), 12'h004);
            end else if (k == 4) begin
                chk("to_abort", outs(), 12'h000);
                chk("to_abort_sde", 12'(sde()), 12'h001);
            end else begin
                chk($sformatf("to_idle%0d", k), outs(), 12'h000);
                chk($sformatf("to_idle%0d_sde", k), 12'(sde()), 12'h000);
            end
`else
            chk($sformatf("wait_hold%0d", k), outs(), mk(0, 0, 1, 0, 0, 2'b00, 3'd1));
            chk($sformatf("wait_hold%0d_sde", k), 12'(sde()), 12'h004);
`endif
        end
`ifndef MAIN_DECODER_BURST_TIMEOUT_EN
        mem_ready = 1'b1;
        for (int ch = 2; ch <= 4; ch++) begin
            tick();
            chk($sformatf("wait_ch%0d", ch), outs(), mk(0, 0, 1, 0, 0, 2'b00, 3'(ch)));
        end
        tick();
        chk("wait_exit_sde", 12'(sde()), 12'h002);
        mem_ready = 1'b0;
        tick();
`endif

        // Reset asserted during beat 2
        present(2'b11, 2'b10, 1'b0, 1'b1);
        mem_ready = 1'b0;
        tick();
        valid     = 1'b0;
        mem_ready = 1'b1;
        tick();
        chk("rst_beat2", outs(), mk(0, 0, 1, 0, 0, 2'b00, 3'd2));
        mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outs", outs(), 12'h000);
        chk("rst_async_sde", 12'(sde()), 12'h000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_after_outs", outs(), 12'h000);
        chk("rst_after_sde", 12'(sde()), 12'h000);
        present(2'b00, 2'b01, 1'b0, 1'b0);
        tick();
        chk("rst_idle_accept", outs(), mk(1, 0, 0, 0, 0, 2'b10, 3'd0));
        valid = 1'b0;
        tick();

        // CMP presented during stall is ignored, re-presentation is accepted
        present(2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk("stall_first", outs(), mk(1, 0, 0, 0, 0, 2'b10, 3'd0));
        present(2'b10, 2'b10, 1'b0, 1'b0);
        tick();
        chk("stall_ignored", outs(), 12'h000);
        chk("stall_ignored_sde", 12'(sde()), 12'h000);
        tick();
        chk("stall_repres", outs(), mk(0, 0, 0, 0, 0, 2'b01, 3'd0));
        chk("stall_repres_sde", 12'(sde()), 12'h004);
        valid = 1'b0;
        tick();
        chk("final_idle", outs(), 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
